// File: rtl/seq_divider_pkg.sv
// seq_divider shared types: FSM state enum and counter sizing helper.
// Used by the top and the sign fix-up sub-module.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_sign.sv
// seq_divider sign handling: operand magnitudes on the way in,
// quotient/remainder sign restoration on the way out.
module seq_divider_sign
  import seq_divider_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] mag_a_o,
  output logic [WIDTH-1:0] mag_b_o,
  output logic             neg_q_o,
  output logic             neg_r_o,
  input  logic [WIDTH-1:0] raw_q_i,
  input  logic [WIDTH-1:0] raw_r_i,
  input  logic             neg_q_i,
  input  logic             neg_r_i,
  input  logic             div0_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] neg(
    input logic [WIDTH-1:0] x
  );
    return WIDTH'(~x + ONE);
  endfunction

  logic sa;
  logic sb;

  // magnitudes and result sign flags from the request operands
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    if (SIGNED) begin
      sa = dividend_i[WIDTH-1];
      sb = divisor_i[WIDTH-1];
    end
    mag_a_o = sa ? $unsigned(neg(dividend_i))
                 : $unsigned(dividend_i);
    mag_b_o = sb ? $unsigned(neg(divisor_i))
                 : $unsigned(divisor_i);
    neg_q_o = sa ^ sb;
    neg_r_o = sa;
  end

  // restore signs; a zero divisor forces an all-ones quotient
  always_comb begin
    quo_o = neg_q_i ? neg(raw_q_i) : raw_q_i;
    if (div0_i) begin
      quo_o = '1;
    end
    rem_o = neg_r_i ? neg(raw_r_i) : raw_r_i;
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per cycle.
// Optional SEQ_DIVIDER_DIV0_EN: zero divisor short-cuts to DONE with out_div0.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder
`ifdef SEQ_DIVIDER_DIV0_EN
  ,
  output logic             out_div0
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT1 = CW'(1);

  state_e state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             nq_q, nq_d;
  logic             nr_q, nr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`ifdef SEQ_DIVIDER_DIV0_EN
  logic             div0_q, div0_d;
`endif

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;
  logic             div_zero;

  seq_divider_sign #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_sign (
    .dividend_i (in_dividend),
    .divisor_i  (in_divisor),
    .mag_a_o    (mag_a),
    .mag_b_o    (mag_b),
    .neg_q_o    (neg_q),
    .neg_r_o    (neg_r),
    .raw_q_i    (a_nxt),
    .raw_r_i    (r_nxt),
    .neg_q_i    (nq_q),
    .neg_r_i    (nr_q),
    .div0_i     (dz_q),
    .quo_o      (fix_q),
    .rem_o      (fix_r)
  );

  assign div_zero = (in_divisor == '0);

  // one restoring step: shift in the next dividend bit, try to subtract
  always_comb begin
    trial = {r_q, a_q[WIDTH-1]};
    diff  = trial - {1'b0, b_q};
    ge    = ~diff[WIDTH];
    r_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    a_nxt = {a_q[WIDTH-2:0], ge};
  end

  // next-state, handshake outputs and datapath loads
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    nq_d      = nq_q;
    nr_d      = nr_q;
    dz_d      = dz_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
`ifdef SEQ_DIVIDER_DIV0_EN
    div0_d    = div0_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d   = mag_a;
          b_d   = mag_b;
          r_d   = '0;
          cnt_d = '0;
          nq_d  = neg_q;
          nr_d  = neg_r;
          dz_d  = div_zero;
`ifdef SEQ_DIVIDER_DIV0_EN
          div0_d = div_zero;
          if (div_zero) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = in_dividend;
          end else begin
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        a_d   = a_nxt;
        r_d   = r_nxt;
        cnt_d = cnt_q + CNT1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          quo_d   = fix_q;
          rem_d   = fix_r;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state register and iteration counter
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // operand, partial remainder and result registers
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      nq_q   <= 1'b0;
      nr_q   <= 1'b0;
      dz_q   <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
`ifdef SEQ_DIVIDER_DIV0_EN
      div0_q <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      nq_q   <= nq_d;
      nr_q   <= nr_d;
      dz_q   <= dz_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
`ifdef SEQ_DIVIDER_DIV0_EN
      div0_q <= div0_d;
`endif
    end
  end

  assign out_quotient  = quo_q;
  assign out_remainder = rem_q;
`ifdef SEQ_DIVIDER_DIV0_EN
  assign out_div0      = div0_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: unsigned and signed 8-bit instances driven in lockstep.
// An integer-arithmetic model predicts results; literals pin each vector.
`timescale 1ns/1ps
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] dvd = 8'd0;
  logic [7:0] dvs = 8'd0;
  logic u_ready, u_valid, s_ready, s_valid;
  logic [7:0] u_q, u_r, s_q, s_r;
`ifdef SEQ_DIVIDER_DIV0_EN
  logic u_dz, s_dz;
  logic exp_dz = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic pending = 1'b0;
  logic [15:0] exp_u = 16'd0;
  logic [15:0] exp_s = 16'd0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8), .SIGNED(1'b0)) u_dut (
    .clock         (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (u_ready),
    .in_dividend   (dvd),
    .in_divisor    (dvs),
    .out_valid     (u_valid),
    .out_ready     (out_ready),
    .out_quotient  (u_q),
`ifdef SEQ_DIVIDER_DIV0_EN
    .out_remainder (u_r),
    .out_div0      (u_dz)
`else
    .out_remainder (u_r)
`endif
  );

  seq_divider #(.WIDTH(8), .SIGNED(1'b1)) s_dut (
    .clock         (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (s_ready),
    .in_dividend   (dvd),
    .in_divisor    (dvs),
    .out_valid     (s_valid),
    .out_ready     (out_ready),
    .out_quotient  (s_q),
`ifdef SEQ_DIVIDER_DIV0_EN
    .out_remainder (s_r),
    .out_div0      (s_dz)
`else
    .out_remainder (s_r)
`endif
  );

  function automatic logic [15:0] model(
    input logic [7:0] a, input logic [7:0] b, input bit sgn
  );
    int qi, ri, sa, sb;
    if (b == 8'd0) return {8'hFF, a};
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      qi = sa / sb;
      ri = sa - qi * sb;
    end else begin
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
    end
    return {qi[7:0], ri[7:0]};
  endfunction

  function automatic int exp_edges(input logic [7:0] b);
`ifdef SEQ_DIVIDER_DIV0_EN
    if (b == 8'd0) return 1;
`endif
    return 9;
  endfunction

  task automatic chk(
    input string name, input logic [31:0] act, input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pending) begin
        chk("lockstep", {31'd0, u_valid}, {31'd0, s_valid});
        if (u_valid) begin
          chk("u_quo", {24'd0, u_q}, {24'd0, exp_u[15:8]});
          chk("u_rem", {24'd0, u_r}, {24'd0, exp_u[7:0]});
          chk("s_quo", {24'd0, s_q}, {24'd0, exp_s[15:8]});
          chk("s_rem", {24'd0, s_r}, {24'd0, exp_s[7:0]});
          chk("ready_in_done", {31'd0, u_ready | s_ready}, 32'd0);
`ifdef SEQ_DIVIDER_DIV0_EN
          chk("u_div0", {31'd0, u_dz}, {31'd0, exp_dz});
          chk("s_div0", {31'd0, s_dz}, {31'd0, exp_dz});
`endif
        end
      end else begin
        chk("idle_valid", {31'd0, u_valid | s_valid}, 32'd0);
      end
    end
  end

  task automatic do_op(
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] uq, input logic [7:0] ur,
    input logic [7:0] sq, input logic [7:0] sr,
    input int hold
  );
    int edges;
    chk("accept_ready", {31'd0, u_ready & s_ready}, 32'd1);
    dvd = a;
    dvs = b;
    in_valid = 1'b1;
    exp_u = model(a, b, 1'b0);
    exp_s = model(a, b, 1'b1);
`ifdef SEQ_DIVIDER_DIV0_EN
    exp_dz = (b == 8'd0);
`endif
    @(posedge clk); #1;
    pending = 1'b1;
    in_valid = 1'b0;
    dvd = 8'($urandom);
    dvs = 8'($urandom);
    edges = 1;
    while (!u_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, exp_edges(b));
    chk("u_lit_q", {24'd0, u_q}, {24'd0, uq});
    chk("u_lit_r", {24'd0, u_r}, {24'd0, ur});
    chk("s_lit_q", {24'd0, s_q}, {24'd0, sq});
    chk("s_lit_r", {24'd0, s_r}, {24'd0, sr});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, u_valid & s_valid}, 32'd1);
      chk("hold_ready", {31'd0, u_ready | s_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    pending = 1'b0;
    chk("release", {28'd0, u_valid, s_valid, u_ready, s_ready},
        32'b0011);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", {31'd0, u_ready & s_ready}, 32'd1);
    chk("rst_valid", {31'd0, u_valid | s_valid}, 32'd0);
    chk("rst_res", {u_q, u_r, s_q, s_r}, 32'd0);

    do_op(8'd100, 8'd7,   8'd14,  8'd2,   8'd14,  8'd2,   0);
    do_op(8'h9C,  8'd7,   8'd22,  8'd2,   8'hF2,  8'hFE,  0);
    do_op(8'd100, 8'hF9,  8'd0,   8'd100, 8'hF2,  8'd2,   0);
    do_op(8'h80,  8'hFF,  8'd0,   8'h80,  8'h80,  8'd0,   0);
    do_op(8'd55,  8'd0,   8'hFF,  8'd55,  8'hFF,  8'd55,  0);
    do_op(8'hC8,  8'd0,   8'hFF,  8'hC8,  8'hFF,  8'hC8,  0);
    do_op(8'hFF,  8'd3,   8'd85,  8'd0,   8'd0,   8'hFF,  5);
    do_op(8'h7F,  8'd1,   8'd127, 8'd0,   8'd127, 8'd0,   0);

    chk("mid_ready", {31'd0, u_ready & s_ready}, 32'd1);
    dvd = 8'h55;
    dvs = 8'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_ready", {31'd0, u_ready & s_ready}, 32'd1);
    chk("abort_valid", {31'd0, u_valid | s_valid}, 32'd0);
    chk("abort_res", {u_q, u_r, s_q, s_r}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_quiet", {31'd0, u_valid | s_valid}, 32'd0);

    do_op(8'd200, 8'd16,  8'd12,  8'd8,   8'hFD,  8'hF8,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range 2..32.
REQ-002 Parameter SIGNED, default 0, SHALL select two's-complement division (1) or unsigned division (0).
REQ-003 clock  input  1  SHALL be the sole clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that the request operands are valid.
REQ-006 in_ready  output  1  SHALL indicate that a request can be accepted.
REQ-007 in_dividend  input  WIDTH  SHALL carry the dividend.
REQ-008 in_divisor  input  WIDTH  SHALL carry the divisor.
REQ-009 out_valid  output  1  SHALL indicate that results are held valid.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts the results.
REQ-011 out_quotient  output  WIDTH  SHALL carry the quotient.
REQ-012 out_remainder  output  WIDTH  SHALL carry the remainder.
REQ-013 out_div0  output  1  SHALL flag a zero divisor; this port exists only under SEQ_DIVIDER_DIV0_EN.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 IDLE->BUSY SHALL occur on in_valid&&in_ready; operands are captured on that edge, and the iteration counter is cleared.
REQ-017 Counter width SHALL be $clog2(WIDTH+1) bits.
REQ-018 BUSY SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit, MSB first.
REQ-019 BUSY->DONE SHALL occur after exactly WIDTH steps, so out_valid rises on the (WIDTH+1)th edge after the accepting edge.
REQ-020 DONE->IDLE SHALL occur on out_valid&&out_ready.
REQ-021 Results SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 No new request SHALL be accepted in the same cycle as a result handshake; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-023 in_dividend and in_divisor changes outside the accepting edge SHALL have no effect.
REQ-024 Unsigned arithmetic SHALL satisfy quotient = floor(dividend/divisor) and remainder = dividend - quotient*divisor.
REQ-025 In SIGNED mode, the datapath SHALL divide magnitudes computed with $unsigned of the absolute values.
REQ-026 In SIGNED mode, the quotient SHALL be negated when the operand signs differ (truncation toward zero).
REQ-027 In SIGNED mode, the remainder SHALL take the sign of the dividend.
REQ-028 In SIGNED mode, the most-negative value divided by -1 SHALL return quotient = most-negative value (wrap) and remainder = 0.
REQ-029 All intermediate results SHALL be truncated to WIDTH bits with explicit width casts.
REQ-030 Divide by zero (base behaviour) SHALL take the full WIDTH steps and return quotient = all ones and remainder = dividend, independent of SIGNED.

Reset
REQ-031 While rst_n=0 at a rising edge, the state SHALL go to IDLE and the counter SHALL clear.
REQ-032 While rst_n=0 at a rising edge, out_quotient, out_remainder and out_div0 SHALL clear to 0.
REQ-033 After reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-034 Reset asserted in BUSY or DONE SHALL abandon the operation with no result delivered.

Configuration
REQ-035 Macro SEQ_DIVIDER_DIV0_EN, when defined, SHALL route a zero divisor IDLE->DONE on the accepting edge (out_valid on the next edge), with out_div0=1, quotient = all ones and remainder = dividend.
REQ-036 With SEQ_DIVIDER_DIV0_EN defined, out_div0 SHALL be 0 for every non-zero divisor.
REQ-037 With SEQ_DIVIDER_DIV0_EN undefined, the out_div0 port SHALL be absent and REQ-030 SHALL apply.

Structure
REQ-038 Package seq_divider_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the counter-width helper built on $clog2.
REQ-039 Sub-module seq_divider_sign SHALL perform the combinational magnitude extraction and the quotient/remainder sign fix-up, parametrised by WIDTH.

Verification
REQ-040 Scenario, WIDTH=8, SIGNED=0: 100/7 -> quotient 14, remainder 2, out_valid 9 edges after accept.
REQ-041 Scenario, WIDTH=8, SIGNED=1: -100/7 -> quotient -14 (8'hF2), remainder -2 (8'hFE); and 100/-7 -> quotient -14, remainder 2.
REQ-042 Scenario, WIDTH=8, SIGNED=1: -128/-1 -> quotient 8'h80, remainder 0.
REQ-043 Scenario: divisor 0, dividend 55 -> quotient 8'hFF, remainder 55; with the macro, out_div0=1 and out_valid 1 edge after accept, otherwise out_valid 9 edges after accept.
REQ-044 Scenario: out_ready held 0 for 5 cycles in DONE -> results stable and in_ready=0 throughout; release -> IDLE on the next edge.
REQ-045 Scenario: rst_n=0 for one edge mid-BUSY -> IDLE, outputs 0, no out_valid pulse; a following request of 200/16 -> quotient 12, remainder 8.
